// File: rtl/bridge_ahb_slave_if_if.sv
// AHB bus bundle seen by the bridge front end.
// The master modport drives the address/data phase; the slave modport
// returns the bridge-local ready and response.
interface bridge_ahb_slave_if_if;
  logic        HSELx;
  logic        HREADYin;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport master (
    output HSELx, HREADYin, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    input  HREADYOUT, HRESP
  );

  modport slave (
    input  HSELx, HREADYin, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    output HREADYOUT, HRESP
  );
endinterface

// File: rtl/bridge_ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge.
// Decodes the APB slave window, qualifies accepted transfers with `valid`,
// pipelines address/write-data/direction two deep, and terminates unmapped
// (and optionally misaligned) transfers with a two-cycle ERROR response.
// Optional feature: define BRIDGE_ALIGN_CHECK_EN to flag misaligned
// transfers (HSIZE vs. HADDR low bits) as errors.
module bridge_ahb_slave_if #(
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  bridge_ahb_slave_if_if.slave       ahb,
  output logic                       valid,
  output logic [2:0]                 tempselx,
  output logic [31:0]                haddr_1,
  output logic [31:0]                haddr_2,
  output logic [31:0]                hwdata_1,
  output logic [31:0]                hwdata_2,
  output logic                       hwrite_reg,
  output logic                       hwrite_reg_1
);

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t      state_reg;
  logic        hreadyout_reg;
  logic [1:0]  hresp_reg;

  logic        active;
  logic        align_err;
  logic        err_xfer;

  // Address window decode; 33-bit compare so a window ending at 4 GiB
  // does not wrap.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_decode
      localparam logic [31:0] BASE = (gi == 0) ? SLV0_BASE :
                                     (gi == 1) ? SLV1_BASE : SLV2_BASE;
      localparam logic [32:0] LO   = {1'b0, BASE};
      localparam logic [32:0] HI   = {1'b0, BASE} + {1'b0, SLV_SIZE};
      assign tempselx[gi] = ({1'b0, ahb.HADDR} >= LO) &&
                            ({1'b0, ahb.HADDR} <  HI);
    end
  endgenerate

  // NONSEQ and SEQ are the only transfer types that start a data phase.
  assign active = ahb.HSELx && ahb.HREADYin && ahb.HTRANS[1];

`ifdef BRIDGE_ALIGN_CHECK_EN
  // Halfword needs bit 0 clear, word needs bits 1:0 clear, wider is illegal.
  always_comb begin
    align_err = 1'b0;
    if (active) begin
      if (ahb.HSIZE > 3'b010)
        align_err = 1'b1;
      else if (ahb.HSIZE == 3'b001 && ahb.HADDR[0])
        align_err = 1'b1;
      else if (ahb.HSIZE == 3'b010 && ahb.HADDR[1:0] != 2'b00)
        align_err = 1'b1;
    end
  end
`else
  logic unused_hsize;
  assign unused_hsize = ^ahb.HSIZE;
  assign align_err    = 1'b0;
`endif

  assign err_xfer = active && ((tempselx == 3'b000) || align_err);

  // The APB controller only sees clean, mapped transfers outside ERR1.
  assign valid = HRESETn && active && (tempselx != 3'b000) && !align_err &&
                 (state_reg != ST_ERR1);

  // Two-deep address/data/direction pipelines, frozen while HREADYin is low.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_1      <= '0;
      haddr_2      <= '0;
      hwdata_1     <= '0;
      hwdata_2     <= '0;
      hwrite_reg   <= 1'b0;
      hwrite_reg_1 <= 1'b0;
    end else if (ahb.HREADYin) begin
      haddr_1      <= ahb.HADDR;
      haddr_2      <= haddr_1;
      hwdata_1     <= ahb.HWDATA;
      hwdata_2     <= hwdata_1;
      hwrite_reg   <= ahb.HWRITE;
      hwrite_reg_1 <= hwrite_reg;
    end
  end

  // Error-response FSM with registered HREADYOUT/HRESP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_OKAY;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 2'b00;
    end else begin
      case (state_reg)
        ST_OKAY: begin
          if (err_xfer) begin
            state_reg     <= ST_ERR1;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= 2'b01;
          end else begin
            state_reg     <= ST_OKAY;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 2'b00;
          end
        end
        ST_ERR1: begin
          // Inputs are ignored here: the first error cycle always completes.
          state_reg     <= ST_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 2'b01;
        end
        ST_ERR2: begin
          // Back-to-back errors go straight to ERR1 without an OKAY cycle.
          if (err_xfer) begin
            state_reg     <= ST_ERR1;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= 2'b01;
          end else begin
            state_reg     <= ST_OKAY;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 2'b00;
          end
        end
        default: begin
          state_reg     <= ST_OKAY;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 2'b00;
        end
      endcase
    end
  end

  assign ahb.HREADYOUT = hreadyout_reg;
  assign ahb.HRESP     = hresp_reg;

endmodule

// File: tb/tb_bridge_ahb_slave_if.sv
// Scoreboard bench for bridge_ahb_slave_if: the driver pushes the expected
// per-cycle response from a behavioural model; a monitor pops and compares
// at mid-cycle.
module tb_bridge_ahb_slave_if;

  localparam logic [31:0] B0 = 32'h8000_0000;
  localparam logic [31:0] B1 = 32'h8400_0000;
  localparam logic [31:0] B2 = 32'h8800_0000;
  localparam logic [31:0] SZ = 32'h0400_0000;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  bridge_ahb_slave_if_if bus ();

  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] haddr_1, haddr_2, hwdata_1, hwdata_2;
  logic        hwrite_reg, hwrite_reg_1;

  bridge_ahb_slave_if #(
    .SLV0_BASE(B0), .SLV1_BASE(B1), .SLV2_BASE(B2), .SLV_SIZE(SZ)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .ahb         (bus.slave),
    .valid       (valid),
    .tempselx    (tempselx),
    .haddr_1     (haddr_1),
    .haddr_2     (haddr_2),
    .hwdata_1    (hwdata_1),
    .hwdata_2    (hwdata_2),
    .hwrite_reg  (hwrite_reg),
    .hwrite_reg_1(hwrite_reg_1)
  );

  typedef struct {
    int          cyc;
    logic        valid;
    logic [2:0]  sel;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] a1, a2, d1, d2;
    logic        w1, w2;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  bit driving_done = 0;

  // Behavioural model: history of sampled bus values and error-response phase.
  logic [31:0] addr_h[$];
  logic [31:0] data_h[$];
  logic        wr_h[$];
  int          err_phase = 0;   // 0 none, 1 first error cycle, 2 second

  function automatic logic [2:0] model_sel(input logic [31:0] a);
    longint unsigned bases[3];
    logic [2:0] s;
    bases[0] = B0; bases[1] = B1; bases[2] = B2;
    s = 3'b000;
    for (int i = 0; i < 3; i++)
      if (longint'(a) >= bases[i] && longint'(a) - bases[i] < longint'(SZ))
        s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic model_misaligned(input logic [2:0] sz, input logic [31:0] a);
`ifdef BRIDGE_ALIGN_CHECK_EN
    int bytes;
    if (sz > 3'd2) return 1'b1;
    bytes = 1 << sz;
    return (a % bytes) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic sel, input logic rdy, input logic [1:0] tr,
                       input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic rstn);
    exp_t e;
    logic [2:0] s;
    logic act, bad;
    logic [31:0] wd;
    @(posedge HCLK);
    #2;
    wd = $urandom;
    bus.HSELx = sel; bus.HREADYin = rdy; bus.HTRANS = tr; bus.HWRITE = wr;
    bus.HSIZE = sz; bus.HADDR = a; bus.HWDATA = wd; HRESETn = rstn;
    if (!rstn) begin
      addr_h.delete(); data_h.delete(); wr_h.delete(); err_phase = 0;
    end
    s   = model_sel(a);
    act = sel && rdy && (tr == 2'b10 || tr == 2'b11);
    bad = act && (s == 3'b000 || model_misaligned(sz, a));
    e.cyc   = cyc_n;
    e.sel   = s;
    e.valid = rstn && act && !bad && err_phase != 1;
    e.rdy   = (err_phase != 1);
    e.resp  = (err_phase == 0) ? 2'b00 : 2'b01;
    e.a1 = (addr_h.size() >= 1) ? addr_h[addr_h.size()-1] : 32'h0;
    e.a2 = (addr_h.size() >= 2) ? addr_h[addr_h.size()-2] : 32'h0;
    e.d1 = (data_h.size() >= 1) ? data_h[data_h.size()-1] : 32'h0;
    e.d2 = (data_h.size() >= 2) ? data_h[data_h.size()-2] : 32'h0;
    e.w1 = (wr_h.size() >= 1) ? wr_h[wr_h.size()-1] : 1'b0;
    e.w2 = (wr_h.size() >= 2) ? wr_h[wr_h.size()-2] : 1'b0;
    exp_q.push_back(e);
    cyc_n++;
    // Advance the model to what the next clock edge will produce.
    if (rstn) begin
      if (rdy) begin
        addr_h.push_back(a); data_h.push_back(wd); wr_h.push_back(wr);
        if (addr_h.size() > 4) begin
          void'(addr_h.pop_front()); void'(data_h.pop_front()); void'(wr_h.pop_front());
        end
      end
      if (err_phase == 1) err_phase = 2;
      else err_phase = bad ? 1 : 0;
    end
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL cyc=%0d %s actual=%h required=%h", cyc, name, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation at mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid",     e.cyc, 32'(valid),         32'(e.valid));
        chk("tempselx",  e.cyc, 32'(tempselx),      32'(e.sel));
        chk("hreadyout", e.cyc, 32'(bus.HREADYOUT), 32'(e.rdy));
        chk("hresp",     e.cyc, 32'(bus.HRESP),     32'(e.resp));
        chk("haddr_1",   e.cyc, haddr_1,            e.a1);
        chk("haddr_2",   e.cyc, haddr_2,            e.a2);
        chk("hwdata_1",  e.cyc, hwdata_1,           e.d1);
        chk("hwdata_2",  e.cyc, hwdata_2,           e.d2);
        chk("hwrite_reg",   e.cyc, 32'(hwrite_reg),   32'(e.w1));
        chk("hwrite_reg_1", e.cyc, 32'(hwrite_reg_1), 32'(e.w2));
        $display("cyc=%0d valid=%0b sel=%b hready=%0b hresp=%b haddr_1=%h haddr_2=%h",
                 e.cyc, valid, tempselx, bus.HREADYOUT, bus.HRESP, haddr_1, haddr_2);
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] pick[8];
    pick[0] = B0 + ($urandom % SZ);
    pick[1] = B1 + ($urandom % SZ);
    pick[2] = B2 + ($urandom % SZ);
    pick[3] = B0 - 32'd1;
    pick[4] = B2 + SZ;
    pick[5] = B1 + SZ - 32'd1;
    pick[6] = $urandom;
    pick[7] = B1;
    return pick[$urandom_range(0, 7)];
  endfunction

  initial begin
    bus.HSELx = 0; bus.HREADYin = 1; bus.HTRANS = 2'b00; bus.HWRITE = 0;
    bus.HSIZE = 3'b010; bus.HADDR = '0; bus.HWDATA = '0;

    // Reset state.
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 0);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 0);
    // NONSEQ/SEQ writes to slave 0.
    drive(1, 1, 2'b10, 1, 3'b010, 32'h8000_0010, 1);
    drive(1, 1, 2'b11, 1, 3'b010, 32'h8000_0014, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h8000_0018, 1);
    // BUSY to slave 1, then HREADYin low holds the pipelines.
    drive(1, 1, 2'b01, 0, 3'b010, 32'h8400_0000, 1);
    drive(1, 0, 2'b10, 1, 3'b010, 32'h8400_0004, 1);
    drive(1, 0, 2'b10, 0, 3'b010, 32'h8800_0008, 1);
    // Unmapped read: ERR1, ERR2, OKAY.
    drive(1, 1, 2'b10, 0, 3'b010, 32'h9000_0000, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h8000_0000, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h8000_0000, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h8000_0000, 1);
    // Back-to-back unmapped: second issued in ERR2.
    drive(1, 1, 2'b10, 0, 3'b010, 32'h9000_0000, 1);
    drive(1, 1, 2'b10, 0, 3'b010, 32'h9000_0004, 1);
    drive(1, 1, 2'b10, 0, 3'b010, 32'h9000_0008, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 1);
    // Misaligned word to slave 2.
    drive(1, 1, 2'b10, 1, 3'b010, 32'h8800_0002, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 1);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 1);
    // Reset asserted during ERR1.
    drive(1, 1, 2'b10, 1, 3'b010, 32'hA000_0000, 1);
    drive(1, 1, 2'b10, 1, 3'b010, 32'h8000_0020, 0);
    drive(1, 1, 2'b00, 0, 3'b010, 32'h0, 1);
    drive(1, 1, 2'b10, 1, 3'b001, 32'h8000_0022, 1);
    drive(1, 1, 2'b00, 0, 3'b000, 32'h8000_0023, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
            2'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
            rand_addr(), ($urandom_range(0, 60) != 0));
    end
    drive(0, 1, 2'b00, 0, 3'b010, 32'h0, 1);

    driving_done = 1;
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge HCLK);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
